// File: rtl/ibex_fp_rf_pkg.sv
// Shared types and helpers for the FP register file.
// Used by ibex_fp_regfile_sb and ibex_fp_rf_scoreboard.
package ibex_fp_rf_pkg;

  typedef logic [4:0] fp_raddr_t;

  localparam int NUM_FP_REGS = 32;

  function automatic logic [63:0] nanbox(
    input logic [63:0] d,
    input logic        single
  );
    return single ? {32'hFFFF_FFFF, d[31:0]} : d;
  endfunction

endpackage

// File: rtl/ibex_fp_rf_scoreboard.sv
// Pending-write scoreboard for the FP register file.
// An alloc to a free register marks it pending; an effective write clears it.
module ibex_fp_rf_scoreboard
  import ibex_fp_rf_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   alloc_valid_i,
  input  fp_raddr_t              alloc_addr_i,
  input  logic [NUM_FP_REGS-1:0] clr_i,
  output logic [NUM_FP_REGS-1:0] pending_o,
  output logic                   alloc_ready_o
);

  logic [NUM_FP_REGS-1:0] r_pending;
  logic [NUM_FP_REGS-1:0] w_pending_d;
  logic                   w_alloc_fire;

  assign alloc_ready_o = ~r_pending[alloc_addr_i];
  assign w_alloc_fire  = alloc_valid_i & alloc_ready_o;
  assign pending_o     = r_pending;

  // Alloc beats a same-cycle clear of the same register.
  always_comb begin
    w_pending_d = r_pending & ~clr_i;
    if (w_alloc_fire) begin
      w_pending_d[alloc_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_d;
    end
  end

endmodule

// File: rtl/ibex_fp_regfile_sb.sv
// FP register file with pending scoreboard and FS dirty tracking.
// Optional FP_RF_WR_BYPASS_EN forwards same-cycle write data to reads.
module ibex_fp_regfile_sb
  import ibex_fp_rf_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int NumRead   = 3,
  parameter int NumWrite  = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumRead-1:0][4:0]            raddr_i,
  output logic [NumRead-1:0][DataWidth-1:0]  rdata_o,
  output logic [NumRead-1:0]                 rvalid_o,
  input  logic                               alloc_valid_i,
  input  logic [4:0]                         alloc_addr_i,
  output logic                               alloc_ready_o,
  input  logic [NumWrite-1:0]                we_i,
  input  logic [NumWrite-1:0][4:0]           waddr_i,
  input  logic [NumWrite-1:0][DataWidth-1:0] wdata_i,
  input  logic [NumWrite-1:0]                wsingle_i,
  input  logic                               fs_clean_i,
  output logic                               fs_dirty_o,
  output logic                               wcollide_o
);

  logic [DataWidth-1:0]   r_regs [NUM_FP_REGS];
  logic                   r_fs_dirty;
  logic [NUM_FP_REGS-1:0] w_reg_we;
  logic [DataWidth-1:0]   w_reg_wd [NUM_FP_REGS];
  logic [NUM_FP_REGS-1:0] w_pending;
  logic [63:0]            w_ext;
  logic [63:0]            w_box;

  // Walk ports high to low so the lowest index lands last and wins.
  always_comb begin
    w_reg_we = '0;
    w_ext    = '0;
    w_box    = '0;
    for (int i = 0; i < NUM_FP_REGS; i++) begin
      w_reg_wd[i] = '0;
    end
    for (int p = NumWrite - 1; p >= 0; p--) begin
      if (we_i[p]) begin
        w_ext = '0;
        w_ext[DataWidth-1:0] = wdata_i[p];
        w_box = nanbox(w_ext, wsingle_i[p] && (DataWidth == 64));
        w_reg_we[waddr_i[p]] = 1'b1;
        w_reg_wd[waddr_i[p]] = w_box[DataWidth-1:0];
      end
    end
  end

  always_comb begin
    wcollide_o = 1'b0;
    for (int p = 1; p < NumWrite; p++) begin
      for (int q = 0; q < p; q++) begin
        if (we_i[p] && we_i[q] && (waddr_i[p] == waddr_i[q])) begin
          wcollide_o = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_FP_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FP_REGS; i++) begin
        if (w_reg_we[i]) begin
          r_regs[i] <= w_reg_wd[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fs_dirty <= 1'b0;
    end else if (|w_reg_we) begin
      r_fs_dirty <= 1'b1;
    end else if (fs_clean_i) begin
      r_fs_dirty <= 1'b0;
    end
  end

  assign fs_dirty_o = r_fs_dirty;

  ibex_fp_rf_scoreboard u_sb (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .alloc_valid_i (alloc_valid_i),
    .alloc_addr_i  (alloc_addr_i),
    .clr_i         (w_reg_we),
    .pending_o     (w_pending),
    .alloc_ready_o (alloc_ready_o)
  );

  always_comb begin
    for (int k = 0; k < NumRead; k++) begin
      rdata_o[k]  = r_regs[raddr_i[k]];
      rvalid_o[k] = ~w_pending[raddr_i[k]];
`ifdef FP_RF_WR_BYPASS_EN
      if (w_reg_we[raddr_i[k]]) begin
        rdata_o[k]  = w_reg_wd[raddr_i[k]];
        rvalid_o[k] = 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ibex_fp_regfile_sb.sv
// Self-checking bench for ibex_fp_regfile_sb (DataWidth=64).
// Expected read data flows through a scoreboard queue.
module tb_ibex_fp_regfile_sb;

  localparam int DW = 64;
  localparam int NR = 3;
  localparam int NW = 2;

  logic                    clk;
  logic                    rst;
  logic [NR-1:0][4:0]      raddr;
  logic [NR-1:0][DW-1:0]   rdata;
  logic [NR-1:0]           rvalid;
  logic                    alloc_valid;
  logic [4:0]              alloc_addr;
  logic                    alloc_ready;
  logic [NW-1:0]           we;
  logic [NW-1:0][4:0]      waddr;
  logic [NW-1:0][DW-1:0]   wdata;
  logic [NW-1:0]           wsingle;
  logic                    fs_clean;
  logic                    fs_dirty;
  logic                    wcollide;

  int checks;
  int failures;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;

  ibex_fp_regfile_sb #(
    .DataWidth (DW),
    .NumRead   (NR),
    .NumWrite  (NW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .raddr_i       (raddr),
    .rdata_o       (rdata),
    .rvalid_o      (rvalid),
    .alloc_valid_i (alloc_valid),
    .alloc_addr_i  (alloc_addr),
    .alloc_ready_o (alloc_ready),
    .we_i          (we),
    .waddr_i       (waddr),
    .wdata_i       (wdata),
    .wsingle_i     (wsingle),
    .fs_clean_i    (fs_clean),
    .fs_dirty_o    (fs_dirty),
    .wcollide_o    (wcollide)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we          = '0;
    waddr       = '0;
    wdata       = '0;
    wsingle     = '0;
    alloc_valid = 1'b0;
    alloc_addr  = '0;
    fs_clean    = 1'b0;
  endtask

  task automatic chk_bit(string name, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic chk_rd(string name, int port);
    exp_v = exp_q.pop_front();
    checks++;
    if (rdata[port] !== exp_v) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, rdata[port], exp_v);
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    rst   = 1'b0;
    raddr = {5'd31, 5'd5, 5'd0};
    for (int i = 0; i < 3; i++) exp_q.push_back('0);
    #1;
    chk_rd("rst_f0", 0);
    chk_rd("rst_f5", 1);
    chk_rd("rst_f31", 2);
    chk_bit("rst_rvalid", (rvalid == 3'b111), 1'b1);
    chk_bit("rst_dirty", fs_dirty, 1'b0);
    chk_bit("rst_collide", wcollide, 1'b0);
    alloc_addr  = 5'd0;
    alloc_valid = 1'b0;
    #1;
    chk_bit("rst_ready_lo", alloc_ready, 1'b1);
  endtask

  task automatic test_nanbox();
    we[0] = 1'b1; waddr[0] = 5'd3;
    wdata[0] = 64'h0000_0000_3F80_0000; wsingle[0] = 1'b1;
    exp_q.push_back(64'hFFFF_FFFF_3F80_0000);
    we[1] = 1'b1; waddr[1] = 5'd10;
    wdata[1] = 64'h1234_5678_9ABC_DEF0; wsingle[1] = 1'b0;
    exp_q.push_back(64'h1234_5678_9ABC_DEF0);
    #1;
    chk_bit("nb_nocollide", wcollide, 1'b0);
    step();
    idle();
    raddr = {5'd0, 5'd10, 5'd3};
    #1;
    chk_rd("nb_f3", 0);
    chk_rd("nb_f10", 1);
    chk_bit("nb_dirty", fs_dirty, 1'b1);
  endtask

  task automatic test_collide();
    we = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7;
    wdata[0] = 64'hA; wdata[1] = 64'hB;
    exp_q.push_back(64'hA);
    #1;
    chk_bit("col_flag", wcollide, 1'b1);
    step();
    idle();
    raddr[0] = 5'd7;
    #1;
    chk_bit("col_flag_clr", wcollide, 1'b0);
    chk_rd("col_f7", 0);
  endtask

  task automatic test_scoreboard();
    alloc_valid = 1'b1; alloc_addr = 5'd9;
    raddr[1] = 5'd9;
    #1;
    chk_bit("sb_ready1", alloc_ready, 1'b1);
    step();
    #1;
    chk_bit("sb_ready2", alloc_ready, 1'b0);
    chk_bit("sb_rvalid_pend", rvalid[1], 1'b0);
    step();
    chk_bit("sb_stall_keep", rvalid[1], 1'b0);
    alloc_valid = 1'b0;
    we[1] = 1'b1; waddr[1] = 5'd9; wdata[1] = 64'h1234;
    exp_q.push_back(64'h1234);
    step();
    idle();
    #1;
    chk_bit("sb_rvalid_clr", rvalid[1], 1'b1);
    chk_rd("sb_f9", 1);
    chk_bit("sb_ready3", alloc_ready, 1'b1);
  endtask

  task automatic test_alloc_write();
    alloc_valid = 1'b1; alloc_addr = 5'd4;
    we[0] = 1'b1; waddr[0] = 5'd4; wdata[0] = 64'h77;
    exp_q.push_back(64'h77);
    step();
    idle();
    raddr[2] = 5'd4;
    #1;
    chk_bit("aw_pending", rvalid[2], 1'b0);
    chk_rd("aw_f4", 2);
    we[0] = 1'b1; waddr[0] = 5'd4; wdata[0] = 64'h78;
    step();
    idle();
    #1;
    chk_bit("aw_release", rvalid[2], 1'b1);
  endtask

  task automatic test_fs();
    fs_clean = 1'b1;
    we[0] = 1'b1; waddr[0] = 5'd11; wdata[0] = 64'h1;
    step();
    idle();
    chk_bit("fs_write_wins", fs_dirty, 1'b1);
    fs_clean = 1'b1;
    step();
    idle();
    chk_bit("fs_clean", fs_dirty, 1'b0);
    step();
    chk_bit("fs_stay_clean", fs_dirty, 1'b0);
  endtask

  task automatic test_bypass();
    raddr[0] = 5'd2;
    we[0] = 1'b1; waddr[0] = 5'd2; wdata[0] = 64'h55;
`ifdef FP_RF_WR_BYPASS_EN
    exp_q.push_back(64'h55);
`else
    exp_q.push_back(64'h0);
`endif
    exp_q.push_back(64'h55);
    #1;
    chk_rd("byp_same", 0);
    step();
    idle();
    #1;
    chk_rd("byp_next", 0);
    alloc_valid = 1'b1; alloc_addr = 5'd12;
    step();
    idle();
    raddr[1] = 5'd12;
    we[1] = 1'b1; waddr[1] = 5'd12; wdata[1] = 64'h9;
    #1;
`ifdef FP_RF_WR_BYPASS_EN
    chk_bit("byp_rvalid", rvalid[1], 1'b1);
`else
    chk_bit("byp_rvalid", rvalid[1], 1'b0);
`endif
    step();
    idle();
    #1;
    chk_bit("byp_rvalid_nx", rvalid[1], 1'b1);
  endtask

  task automatic test_reset_mid();
    alloc_valid = 1'b1; alloc_addr = 5'd13;
    step();
    idle();
    rst = 1'b1;
    we[0] = 1'b1; waddr[0] = 5'd14; wdata[0] = 64'h99;
    step();
    rst = 1'b0;
    idle();
    raddr = {5'd3, 5'd14, 5'd13};
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h0);
    #1;
    chk_bit("rm_pend_drop", rvalid[0], 1'b1);
    chk_rd("rm_f14", 1);
    chk_rd("rm_f3", 2);
    chk_bit("rm_dirty", fs_dirty, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    raddr    = '0;
    idle();
    test_reset();
    test_nanbox();
    test_collide();
    test_scoreboard();
    test_alloc_write();
    test_fs();
    test_bypass();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
